// File: rtl/keypad_ram_loader_pkg.sv
// Shared types and helpers for the keypad-driven program RAM loader.
`ifndef WORDSIZE
`define WORDSIZE 8
`endif

package keypad_ram_loader_pkg;

  // Loader FSM encoding
  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_WR    = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int NUM_KEYS = 16;

  // Ceiling log2. The result is at least 1, so a counter built from it is never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/keypad_ram_loader_key_event_detect.sv
// Turns debounced keypad levels into single-cycle digit and done events.
// A held key yields one event. Simultaneous rises on several keys are ignored.
module key_event_detect
  import keypad_ram_loader_pkg::*;
(
  input  logic                init_clock,
  input  logic                init_reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                key_done,
  output logic                digit_valid,
  output logic [3:0]          digit,
  output logic                done_pulse
);

  logic [NUM_KEYS-1:0] keys_q;
  logic [NUM_KEYS-1:0] rise;
  logic                done_q;
  logic [4:0]          rise_cnt;

  // Previous levels. Reset to "all pressed" so a key held through reset release is not seen as new.
  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      keys_q <= '1;
      done_q <= 1'b1;
    end else begin
      keys_q <= keys;
      done_q <= key_done;
    end
  end

  assign rise = keys & ~keys_q;

  // Popcount of rising keys. The index of the last set bit is used only when exactly one bit is set.
  always_comb begin
    rise_cnt = '0;
    digit    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        rise_cnt = rise_cnt + 5'd1;
        digit    = 4'(i);
      end
    end
  end

  assign digit_valid = (rise_cnt == 5'd1);
  assign done_pulse  = key_done & ~done_q;

endmodule

// File: rtl/keypad_ram_loader.sv
// Collects hex digits from the keypad into words and writes them to program RAM.
// load_done is sticky. It hands the RAM address and clock over to the CPU.
module keypad_ram_loader
  import keypad_ram_loader_pkg::*;
#(
  parameter  int DATA_W = `WORDSIZE,
  parameter  int ADDR_W = 2,
  parameter  int DEPTH  = 4,
  localparam int NDIG   = DATA_W / 4,
  localparam int CNT_W  = clog2(NDIG + 1)
) (
  input  logic                init_clock,
  input  logic                init_reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                key_done,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_we,
  output logic                load_done,
  output logic [DATA_W-1:0]   entry_value,
  output logic [CNT_W-1:0]    digit_cnt
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   entry, entry_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic                done_nxt;
  logic                digit_valid;
  logic [3:0]          digit;
  logic                done_pulse;

  key_event_detect u_evt (
    .init_clock  (init_clock),
    .init_reset  (init_reset),
    .keys        (keys),
    .key_done    (key_done),
    .digit_valid (digit_valid),
    .digit       (digit),
    .done_pulse  (done_pulse)
  );

  // State register
  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) state <= S_ENTRY;
    else            state <= state_nxt;
  end

  // Next state and datapath updates. The done button wins over a digit arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    entry_nxt = entry;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    done_nxt  = load_done;
    case (state)
      S_ENTRY: begin
        if (done_pulse) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (digit_valid) begin
          entry_nxt = (entry << 4) | DATA_W'(digit);
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(NDIG)) state_nxt = S_WR;
        end
      end
      S_WR: begin
        entry_nxt = '0;
        cnt_nxt   = '0;
        if (addr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = S_ENTRY;
        end
      end
      S_DONE: begin
        // Terminal state. Only reset leaves it.
      end
      default: state_nxt = S_ENTRY;
    endcase
  end

  // Datapath registers. ram_we comes from a flop so it is glitch-free and lines up with S_WR.
  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      entry     <= '0;
      cnt       <= '0;
      addr      <= '0;
      load_done <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      entry     <= entry_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      load_done <= done_nxt;
      ram_we    <= (state_nxt == S_WR);
    end
  end

  assign ram_addr    = addr;
  assign ram_data    = entry;
  assign entry_value = entry;
  assign digit_cnt   = cnt;

endmodule
